xadc_scan_sequencer: RTL

Sequences XADC DRP reads across up to four auxiliary analog channels in round-robin order, driven by the XADC end-of-conversion flag. It owns the DRP port (enable, address, write-enable) and publishes each channel's latest 12-bit result plus a per-sample strobe. Downstream consumers are the LED PWM logic and the transfer-function/DAC path.

---
 rtl/xadc_scan_sequencer.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/xadc_scan_sequencer.sv
// rtl/xadc_scan_sequencer.sv - round-robin XADC DRP read sequencer for up to four aux channels
//
// Purpose: waits for the XADC end-of-conversion flag, issues one DRP read at the
// current slot's address, captures the 12-bit result and publishes it. Slots
// are taken in round-robin order over the set bits of ch_mask.
//
// Optional feature: define XADC_SCAN_AVG_EN to publish the mean of every four
// samples per slot instead of every raw sample.
//
// Ports:
//   clk           system clock (also the XADC dclk)
//   rst           synchronous active-high reset
//   enable        run scanning while high
//   ch_mask[3:0]  bit i enables slot i
//   eoc_in        XADC end-of-conversion
//   drdy_in       XADC DRP data ready
//   do_in[15:0]   XADC DRP read data
//   den_out       DRP enable, one-cycle pulse
//   dwe_out       DRP write enable, tied low
//   daddr_out     DRP address of the current slot
//   sample_valid  one-cycle strobe for a newly published result
//   sample_ch     slot index of the published result
//   sample_data   published 12-bit result
//   data_flat     latest result per slot, slot i at [12i+11:12i]
//   timeout_err   sticky drdy timeout flag
//   busy          high whenever the sequencer is not idle

module xadc_scan_sequencer #(
  parameter logic [6:0]  ADDR0   = 7'h16,
  parameter logic [6:0]  ADDR1   = 7'h17,
  parameter logic [6:0]  ADDR2   = 7'h1E,
  parameter logic [6:0]  ADDR3   = 7'h1F,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  ch_mask,
  input  logic        eoc_in,
  input  logic        drdy_in,
  input  logic [15:0] do_in,
  output logic        den_out,
  output logic        dwe_out,
  output logic [6:0]  daddr_out,
  output logic        sample_valid,
  output logic [1:0]  sample_ch,
  output logic [11:0] sample_data,
  output logic [47:0] data_flat,
  output logic        timeout_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EOC,
    ISSUE,
    WAIT_RDY,
    STORE
  } state_t;

  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nx;
  logic [1:0]  ptr;
  logic [9:0]  tmo_cnt;
  logic        run;
  logic        tmo_hit;
  logic [1:0]  ptr_first;
  logic [1:0]  ptr_next;
  logic [11:0] raw_sample;
  logic        unused_do_lsb;

  // Returns the first enabled slot starting at cur (incl=1) or after cur
  // (incl=0), wrapping 3->0. With an empty mask cur is returned unchanged.
  function automatic logic [1:0] pick_slot(input logic [3:0] mask,
                                           input logic [1:0] cur,
                                           input logic       incl);
    logic [1:0] res;
    logic [1:0] idx;
    logic       found;
    res   = cur;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = incl ? (cur + 2'(k)) : (cur + 2'(k + 1));
      if (!found && mask[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign run           = enable && (ch_mask != 4'b0000);
  assign tmo_hit       = (state == WAIT_RDY) && !drdy_in && (tmo_cnt == TMO_LAST);
  assign ptr_first     = pick_slot(ch_mask, ptr, 1'b1);
  assign ptr_next      = pick_slot(ch_mask, ptr, 1'b0);
  assign raw_sample    = do_in[15:4];
  assign unused_do_lsb = ^do_in[3:0];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (run) state_nx = WAIT_EOC;
      // No read is in flight here, so a stopped scan can idle immediately.
      WAIT_EOC: begin
        if (!run)        state_nx = IDLE;
        else if (eoc_in) state_nx = ISSUE;
      end
      ISSUE:    state_nx = WAIT_RDY;
      WAIT_RDY: begin
        if (drdy_in)      state_nx = STORE;
        else if (tmo_hit) state_nx = run ? WAIT_EOC : IDLE;
      end
      STORE:    state_nx = run ? WAIT_EOC : IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    den_out = (state == ISSUE);
    dwe_out = 1'b0;
    busy    = (state != IDLE);
    case (ptr)
      2'd0:    daddr_out = ADDR0;
      2'd1:    daddr_out = ADDR1;
      2'd2:    daddr_out = ADDR2;
      default: daddr_out = ADDR3;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pointer, timeout counter and error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= 2'd0;
      tmo_cnt     <= 10'd0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE:     if (run) ptr <= ptr_first;
        ISSUE:    tmo_cnt <= 10'd0;
        WAIT_RDY: begin
          if (!drdy_in) begin
            tmo_cnt <= tmo_cnt + 10'd1;
            if (tmo_hit) begin
              timeout_err <= 1'b1;
              ptr         <= ptr_next;
            end
          end
        end
        STORE:    ptr <= ptr_next;
        default:  ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Result capture. Results are written on the drdy edge so that data_flat and
  // sample_data are already valid in the STORE cycle that strobes sample_valid.
  // ---------------------------------------------------------------------------
`ifdef XADC_SCAN_AVG_EN
  logic [13:0] acc     [4];
  logic [1:0]  acc_cnt [4];
  logic [13:0] acc_sum;
  logic        pub;

  assign acc_sum      = acc[ptr] + {2'b00, raw_sample};
  assign sample_valid = (state == STORE) && pub;

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_ch   <= 2'd0;
      sample_data <= 12'd0;
      data_flat   <= 48'd0;
      pub         <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        acc[i]     <= 14'd0;
        acc_cnt[i] <= 2'd0;
      end
    end else if (state == WAIT_RDY && drdy_in) begin
      if (acc_cnt[ptr] == 2'd3) begin
        // Fourth sample of this slot: publish the mean and restart the window.
        pub          <= 1'b1;
        sample_ch    <= ptr;
        sample_data  <= acc_sum[13:2];
        acc[ptr]     <= 14'd0;
        acc_cnt[ptr] <= 2'd0;
        for (int i = 0; i < 4; i++) begin
          if (ptr == 2'(i)) data_flat[12*i +: 12] <= acc_sum[13:2];
        end
      end else begin
        pub          <= 1'b0;
        acc[ptr]     <= acc_sum;
        acc_cnt[ptr] <= acc_cnt[ptr] + 2'd1;
      end
    end
  end
`else
  assign sample_valid = (state == STORE);

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_ch   <= 2'd0;
      sample_data <= 12'd0;
      data_flat   <= 48'd0;
    end else if (state == WAIT_RDY && drdy_in) begin
      sample_ch   <= ptr;
      sample_data <= raw_sample;
      for (int i = 0; i < 4; i++) begin
        if (ptr == 2'(i)) data_flat[12*i +: 12] <= raw_sample;
      end
    end
  end
`endif

endmodule
